// File: rtl/scrub_bram_pkg.sv
// Shared types and elaboration helpers for the scrubbable byte-strobed RAM.
// Optional feature macro: SCRUB_BRAM_RAND_SCRUB_EN (see scrub_bram.sv).
package scrub_bram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_e;

  // Legal geometry: whole bytes per word, power-of-two depth of at least two words.
  function automatic bit geometry_ok(input int data_w, input int depth);
    return (data_w >= 8) && ((data_w % 8) == 0) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/scrub_bram_if.sv
// Memory-bus bundle between a CPU-side master and the scrubbable RAM.
// The master holds en until busy is low; accesses during a scrub are dropped.
interface scrub_bram_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8192
);
  localparam int SW = DATA_W / 8;
  localparam int AW = $clog2(DEPTH) + $clog2(SW);

  logic              en;
  logic [SW-1:0]     wen;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              flush_rand;
  logic [DATA_W-1:0] flush_data;
  logic              scrub_req;
  logic              busy;
  logic              scrub_done;

  modport master (
    output en, wen, addr, wdata, flush_rand, flush_data, scrub_req,
    input  rdata, busy, scrub_done
  );

  modport slave (
    input  en, wen, addr, wdata, flush_rand, flush_data, scrub_req,
    output rdata, busy, scrub_done
  );

endinterface

// File: rtl/scrub_bram_ctrl.sv
// Scrub sequencer: IDLE/SCRUB FSM, word counter, busy/scrub_done and the
// access-qualify terms (acc, registered p_acc) that gate reads, writes and flushes.
module scrub_bram_ctrl
  import scrub_bram_pkg::*;
#(
  parameter int DEPTH          = 8192,
  parameter int SCRUB_ON_RESET = 1,
  localparam int LW            = $clog2(DEPTH)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          en_i,
  input  logic          scrub_req_i,
  input  logic          flush_rand_i,
  output logic          acc_o,
  output logic          flush_ok_o,
  output logic          scrub_we_o,
  output logic [LW-1:0] scrub_idx_o,
  output logic          busy_o,
  output logic          scrub_done_o
);

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          p_acc_q;
  logic          boot_q;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scrub_req_i || boot_q) begin
          state_d = SCRUB;
          cnt_d   = '0;
        end
      end
      SCRUB: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      p_acc_q <= 1'b0;
      boot_q  <= (SCRUB_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      p_acc_q <= acc_o;
      boot_q  <= 1'b0;
    end
  end

  // A flush never lands directly after an access, so read data stays visible a cycle.
  assign acc_o        = en_i && (state_q == IDLE);
  assign flush_ok_o   = flush_rand_i && !acc_o && !p_acc_q;
  assign scrub_we_o   = (state_q == SCRUB);
  assign scrub_idx_o  = cnt_q;
  assign busy_o       = (state_q == SCRUB);
  assign scrub_done_o = done_q;

endmodule

// File: rtl/scrub_bram.sv
// Single-port byte-strobed RAM with a randomisable read register and whole-array scrub.
// Define SCRUB_BRAM_RAND_SCRUB_EN to scrub with flush_data instead of zeros.
module scrub_bram
  import scrub_bram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 8192,
  parameter int SCRUB_ON_RESET = 1
) (
  input logic          g_clk,
  input logic          g_resetn,
  scrub_bram_if.slave  bus
);

  localparam int SW = DATA_W / 8;
  localparam int BW = $clog2(SW);
  localparam int LW = $clog2(DEPTH);
  localparam int AW = LW + BW;

  if (!geometry_ok(DATA_W, DEPTH)) begin : g_bad_geometry
    $error("scrub_bram: DATA_W must be a multiple of 8 and DEPTH a power of two >= 2");
  end

  logic          acc;
  logic          flush_ok;
  logic          scrub_we;
  logic [LW-1:0] scrub_idx;
  logic          busy;
  logic          scrub_done;

  scrub_bram_ctrl #(
    .DEPTH         (DEPTH),
    .SCRUB_ON_RESET(SCRUB_ON_RESET)
  ) u_ctrl (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .en_i        (bus.en),
    .scrub_req_i (bus.scrub_req),
    .flush_rand_i(bus.flush_rand),
    .acc_o       (acc),
    .flush_ok_o  (flush_ok),
    .scrub_we_o  (scrub_we),
    .scrub_idx_o (scrub_idx),
    .busy_o      (busy),
    .scrub_done_o(scrub_done)
  );

  logic [LW-1:0]     acc_idx;
  logic [LW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] scrub_word;
  logic [7:0]        rd_byte [SW];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign acc_idx = bus.addr[AW-1:BW];

`ifdef SCRUB_BRAM_RAND_SCRUB_EN
  assign scrub_word = bus.flush_data;
`else
  assign scrub_word = '0;
`endif

  // The scrubber owns the port while busy; acc is never high in that state.
  assign wr_idx  = scrub_we ? scrub_idx  : acc_idx;
  assign wr_word = scrub_we ? scrub_word : bus.wdata;

  for (genvar i = 0; i < SW; i++) begin : g_lane
    logic [7:0] lane_q [DEPTH];
    logic       lane_we;

    assign lane_we = scrub_we || (acc && bus.wen[i]);

    // NOTE: the array has no reset; clearing it is the scrub engine's job, which keeps it RAM-mappable.
    always_ff @(posedge g_clk) begin
      if (lane_we) lane_q[wr_idx] <= wr_word[8*i +: 8];
    end

    assign rd_byte[i] = lane_q[acc_idx];
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < SW; i++) rd_word[8*i +: 8] = rd_byte[i];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (acc && (bus.wen == '0)) rdata_d = rd_word;
    else if (flush_ok)          rdata_d = bus.flush_data;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) rdata_q <= '0;
    else           rdata_q <= rdata_d;
  end

  assign bus.rdata      = rdata_q;
  assign bus.busy       = busy;
  assign bus.scrub_done = scrub_done;

endmodule

// File: doc/scrub_bram.md
# scrub_bram

Parametrised single-port on-chip RAM with byte strobes, a randomisable read register and a hardware scrub engine that overwrites every word on request or after reset. It is the successor to the flushable BRAM used for instruction/data memory behind the CPU memory bus. It adds width/depth generality, a busy handshake and whole-array erasure, closing residue leakage between security contexts.

## Interface
- DATA_W, 32, word width in bits; multiple of 8, at least 8.
- DEPTH, 8192, words; power of two, at least 2.
- SCRUB_ON_RESET, 1, if 1 a scrub starts automatically on reset release.
- Derived: SW = DATA_W/8, BW = $clog2(SW), LW = $clog2(DEPTH), AW = LW+BW.
- g_clk  in  1  single clock, all logic on rising edge.
- g_resetn  in  1  reset, asynchronous, active-low.
- en  in  1  access request.
- wen  in  SW  byte write strobes; all-zero means read.
- addr  in  AW  byte address; word index = addr[AW-1:BW], low BW bits ignored.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  registered read data.
- flush_rand  in  1  enable loading rdata with flush_data when idle.
- flush_data  in  DATA_W  random word from the TRNG/PRNG.
- scrub_req  in  1  single-cycle pulse requesting a full-array scrub.
- busy  out  1  scrub in progress; accesses not performed.
- scrub_done  out  1  one-cycle pulse when a scrub completes.

## Operation
- Reset (g_resetn low, asynchronous): rdata=0, busy=0, scrub_done=0, p_acc=0, counter=0, state=IDLE. Memory array is not reset.
- States: IDLE, SCRUB. busy = (state==SCRUB), registered.
- IDLE -> SCRUB: scrub_req high at an edge, or first edge after reset release when SCRUB_ON_RESET=1. Counter cleared to 0.
- SCRUB: each cycle, all bytes of word[counter] are written with the scrub word, counter increments. At counter==DEPTH-1 write last word, go to IDLE, counter to 0, scrub_done=1 for one cycle.
- scrub_req while SCRUB: ignored, no restart.
- acc = en && state==IDLE. en while busy: dropped, no write and no read; the master must hold the request until busy is low.
- Read (acc, wen==0): rdata <= word[idx] at the edge.
- Write (acc, wen!=0): byte i of word[idx] <= wdata[8i+7:8i] where wen[i]=1; rdata holds.
- Flush: flush_rand && !acc && !p_acc -> rdata <= flush_data, where p_acc is acc registered. This occurs in either state. Otherwise rdata holds.
- Same-cycle scrub_req and acc in IDLE: access completes normally; scrub starts next cycle.
- Reset asserted mid-scrub: scrub aborts, and the array is partially scrubbed. It is rescrubbed after release only if SCRUB_ON_RESET=1.

## Timing
- Read latency 1: en at edge N -> rdata valid after edge N, stable until next read or flush.
- Read-first: a read and a write to the same index cannot coincide (single port). A read at edge N+1 after a write at edge N returns the new data.
- Flush begins no earlier than the second idle cycle after an access: rdata is held for at least one cycle after a read.
- Scrub: scrub_req sampled at edge N -> busy high after N. Writes occur at edges N+1..N+DEPTH. busy low and scrub_done high after edge N+DEPTH. busy is high for exactly DEPTH cycles.
- Counter is LW bits wide; wrap from DEPTH-1 to 0 coincides with leaving SCRUB.

## Configuration
- SCRUB_BRAM_RAND_SCRUB_EN defined: scrub word = flush_data sampled each scrub cycle, so each word gets fresh randomness.
- Not defined: scrub word = all zeros; flush_data is used only for the rdata flush.

## Structure
- Package scrub_bram_pkg: state enum (IDLE, SCRUB), and a width-check function for DATA_W/DEPTH legality, used in elaboration-time assertions.
- Sub-module scrub_bram_ctrl: holds the FSM, scrub counter, busy/scrub_done, and the acc/p_acc generation. The top holds the byte-lane arrays, the write muxing (access vs scrub) and the rdata register.

## Test plan
- Write then read: SCRUB_ON_RESET=0. Write 0xDEADBEEF to addr 0x10 with wen=0xF, then read 0x10 -> rdata=0xDEADBEEF one cycle after the read.
- Byte strobes: with 0xDEADBEEF at 0x10, write 0x11223344 with wen=0x5, then read -> 0xDE22BE44.
- Flush: read 0x10, then idle with flush_rand=1 and flush_data=0xA5A5A5A5. rdata holds 0xDE22BE44 one cycle, then becomes 0xA5A5A5A5.
- Scrub: DEPTH=16, macro undefined, all words written 0xFFFFFFFF, pulse scrub_req. busy is high 16 cycles, scrub_done pulses once, en during busy is ignored, and all reads afterwards return 0.
- Random scrub: macro defined, flush_data = incrementing counter starting at 0x100 on the cycle after scrub_req -> word k reads 0x100+k.
- Reset mid-scrub: assert g_resetn low at cycle 5 of a scrub. busy=0 and rdata=0 immediately. With SCRUB_ON_RESET=1, busy rises on the first edge after release and is high 16 cycles.
